// File: rtl/sram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_responder
//  Purpose  : Memory-side responder for the MEM-stage data interface. Services
//             32-bit word read/write requests on an external 16-bit
//             asynchronous SRAM as two half-word accesses (low half first).
//             ready stays low while an access is in flight so the pipeline
//             freezes until the word is complete.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous reset, active-low
//             wr_en      - word write request (level)
//             rd_en      - word read request (level)
//             address    - byte address from ALU result
//             wdata      - write data
//             rdata      - read data, valid when ready=1 after a read
//             ready      - no access pending / access complete this cycle
//             sram_addr  - SRAM half-word address
//             sram_dq    - SRAM bidirectional data bus
//             sram_we_n  - SRAM write strobe, active-low
//             sram_oe_n  - SRAM output enable, active-low
//  Revision : 1.0 - initial release
// ============================================================================
module sram_mem_responder #(
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_LO   = 2'd1;
    localparam logic [1:0] C_ST_HI   = 2'd2;
    localparam logic [1:0] C_ST_DONE = 2'd3;

    localparam logic [31:0]   C_BASE   = 32'(ADDR_BASE);
    localparam logic [CW-1:0] C_RELOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] C_ZERO   = '0;
    localparam logic [SRAM_AW-1:0] C_HALF_SEL = SRAM_AW'(1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_op;      // 1 = write, 0 = read
    logic [31:0]        r_wdata;

    logic [31:0]        w_off;
    logic [31:0]        w_half;
    logic [SRAM_AW-1:0] w_lo_addr;
    logic               w_active;
    logic               w_drive;
    logic               w_unused;

    // Word index = (address - base) >> 2; half-word address appends a zero
    // LSB. Wrap-around and truncation to the SRAM width are intentional.
    assign w_off     = address - C_BASE;
    assign w_half    = {w_off[31:2], 1'b0};
    assign w_lo_addr = w_half[SRAM_AW-1:0];
    assign w_unused  = ^{w_off[1:0], w_half};

    assign w_active  = (r_state == C_ST_LO) || (r_state == C_ST_HI);
    assign w_drive   = w_active && r_op;

    // Strobes decode from registered state only, so they are glitch-free
    // with respect to the request inputs.
    assign sram_we_n = ~w_drive;
    assign sram_oe_n = ~(w_active && !r_op);
    assign sram_dq   = w_drive ? ((r_state == C_ST_HI) ? r_wdata[31:16] : r_wdata[15:0])
                               : 16'bz;

    always_comb begin
        ready = 1'b0;
        case (r_state)
            C_ST_IDLE: ready = ~(wr_en | rd_en);
            C_ST_DONE: ready = 1'b1;
            default:   ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= C_ST_IDLE;
            r_cnt     <= C_ZERO;
            r_op      <= 1'b0;
            r_wdata   <= 32'd0;
            rdata     <= 32'd0;
            sram_addr <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (wr_en || rd_en) begin
                        r_op      <= wr_en;   // write wins when both are high
                        r_wdata   <= wdata;
                        sram_addr <= w_lo_addr;
                        r_cnt     <= C_RELOAD;
                        r_state   <= C_ST_LO;
                    end
                end
                C_ST_LO: begin
                    if (r_cnt != C_ZERO) begin
                        r_cnt <= r_cnt - C_ONE;
                    end else begin
                        if (!r_op) begin
                            rdata[15:0] <= sram_dq;
                        end
                        sram_addr <= sram_addr | C_HALF_SEL;
                        r_cnt     <= C_RELOAD;
                        r_state   <= C_ST_HI;
                    end
                end
                C_ST_HI: begin
                    if (r_cnt != C_ZERO) begin
                        r_cnt <= r_cnt - C_ONE;
                    end else begin
                        if (!r_op) begin
                            rdata[31:16] <= sram_dq;
                        end
                        r_state <= C_ST_DONE;
                    end
                end
                C_ST_DONE: begin
                    // Requests are ignored here so a held request cannot
                    // restart before the pipeline has advanced.
                    r_state <= C_ST_IDLE;
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_mem_responder
//  Purpose  : Self-checking bench for sram_mem_responder with a behavioural
//             16-bit SRAM. The driver queues the expected bus phases and
//             completion for each request; a negedge monitor pops and checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_mem_responder;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        we_n;
    logic        oe_n;

    sram_mem_responder #(.ADDR_BASE(1024), .SRAM_AW(18), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .sram_addr (sram_addr),
        .sram_dq   (dq),
        .sram_we_n (we_n),
        .sram_oe_n (oe_n)
    );

    // Behavioural SRAM: drives the bus while output-enabled, latches on
    // clock edges while the write strobe is low.
    logic [15:0] mem [0:(1<<18)-1];
    assign dq = (!oe_n) ? mem[sram_addr] : 16'bz;
    always @(posedge clk) begin
        if (!we_n) mem[sram_addr] <= dq;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        bit          wr;
        logic [17:0] addr;
        logic [15:0] data;
        logic [31:0] rdata;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    bit  seen_bus = 0;
    logic [31:0] last_rd = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: bus phases and completions are checked against the queue.
    always @(negedge clk) begin
        ev_t e;
        if (!we_n || !oe_n) begin
            seen_bus = 1;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: addr=0x%05h we_n=%b oe_n=%b", sram_addr, we_n, oe_n);
            end else begin
                e = q.pop_front();
                if (e.is_done || we_n !== !e.wr || oe_n !== e.wr || sram_addr !== e.addr ||
                    ready !== 1'b0 || (e.wr && dq !== e.data)) begin
                    bad++;
                    $display("FAIL bus_phase: got addr=0x%05h we_n=%b oe_n=%b dq=0x%04h rdy=%b want addr=0x%05h wr=%b dq=0x%04h done=%b",
                             sram_addr, we_n, oe_n, dq, ready, e.addr, e.wr, e.data, e.is_done);
                end
            end
        end else if (ready && seen_bus) begin
            seen_bus = 0;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: rdata=0x%08h", rdata);
            end else begin
                e = q.pop_front();
                if (!e.is_done || rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL done_rdata: got 0x%08h want 0x%08h (done_expected=%b)",
                             rdata, e.rdata, e.is_done);
                end
            end
        end
    end

    task automatic push_access(input bit wr, input logic [17:0] lo, input logic [31:0] d,
                               input logic [31:0] exp_rd);
        ev_t e;
        for (int i = 0; i < 2*W; i++) begin
            e.is_done = 0;
            e.wr      = wr;
            e.addr    = (i < W) ? lo : (lo | 18'd1);
            e.data    = (i < W) ? d[15:0] : d[31:16];
            e.rdata   = 32'd0;
            q.push_back(e);
        end
        e.is_done = 1;
        e.wr      = 0;
        e.addr    = '0;
        e.data    = '0;
        e.rdata   = exp_rd;
        q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 40);
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: ready=%b want 1", name, ready);
        end
    endtask

    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [17:0] lo, input string name);
        if (!wr) last_rd = {mem[lo | 18'd1], mem[lo]};
        push_access(wr, lo, d, last_rd);
        @(posedge clk); #2;
        wr_en = wr; rd_en = rd; address = a; wdata = d;
        wait_ready(name);
        @(posedge clk); #2;
        wr_en = 0; rd_en = 0;
    endtask

    initial begin
        rst = 0; wr_en = 0; rd_en = 0; address = 0; wdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_addr", {14'd0, sram_addr}, 32'd0);
        rst = 1;

        // Write, then read back
        do_req(1, 0, 32'd1024, 32'hDEADBEEF, 18'd0, "wr1024");
        chk("mem_lo0", {16'd0, mem[0]}, 32'h0000BEEF);
        chk("mem_hi1", {16'd0, mem[1]}, 32'h0000DEAD);
        do_req(0, 1, 32'd1024, 32'd0, 18'd0, "rd1024");

        // Indexing and wrap
        do_req(1, 0, 32'd1044, 32'h12345678, 18'd10, "wr1044");
        do_req(0, 1, 32'd1044, 32'd0, 18'd10, "rd1044");
        do_req(1, 0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, "wr1020");
        do_req(0, 1, 32'd1020, 32'd0, 18'h3FFFE, "rd1020");

        // Both requests held through DONE: write wins, DONE does not restart
        push_access(1, 18'd2, 32'hCAFEF00D, last_rd);
        push_access(1, 18'd2, 32'hCAFEF00D, last_rd);
        @(posedge clk); #2;
        wr_en = 1; rd_en = 1; address = 32'd1028; wdata = 32'hCAFEF00D;
        wait_ready("both1");
        @(negedge clk);
        chk("gap_ready", {31'd0, ready}, 32'd0);
        chk("gap_we_n", {31'd0, we_n}, 32'd1);
        wait_ready("both2");
        @(posedge clk); #2;
        wr_en = 0; rd_en = 0;
        do_req(0, 1, 32'd1028, 32'd0, 18'd2, "rd1028");

        // Reset during the high half of a write
        begin
            ev_t e;
            for (int i = 0; i < W + 1; i++) begin
                e.is_done = 0; e.wr = 1;
                e.addr  = (i < W) ? 18'd4 : 18'd5;
                e.data  = (i < W) ? 16'h2222 : 16'h1111;
                e.rdata = 32'd0;
                q.push_back(e);
            end
            e.is_done = 1; e.wr = 0; e.addr = '0; e.data = '0; e.rdata = 32'd0;
            q.push_back(e);
        end
        @(posedge clk); #2;
        wr_en = 1; address = 32'd1040 - 32'd8; wdata = 32'h11112222;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(we_n === 1'b0 && sram_addr === 18'd5) && n < 40);
            chk("hi_reached", {14'd0, sram_addr}, 32'd5);
        end
        rst = 0; wr_en = 0;
        @(negedge clk);
        chk("mr_we_n", {31'd0, we_n}, 32'd1);
        chk("mr_ready", {31'd0, ready}, 32'd1);
        chk("mr_rdata", rdata, 32'd0);
        chk("mr_mem_lo", {16'd0, mem[4]}, 32'h00002222);
        rst = 1;

        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
